// File: rtl/spi_slave_adc.sv
// spi_slave_adc: SPI slave emulating a multi-channel ADC; round-robin sample readout on MISO,
// received MOSI words presented as rx_valid pulses, all logic in the clk domain.
module spi_slave_adc #(
    parameter int   DATA_W      = 16,
    parameter int   CHANNELS    = 4,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2,
    localparam int  CW          = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int  BW          = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    input  logic              load_we,
    input  logic [CW-1:0]     load_chan,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [CW-1:0]     rx_chan,
    output logic              frame_err
);
    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                    sclk_prev_q, cs_prev_q;
    logic [DATA_W-1:0]       sample_q [CHANNELS];
    logic [DATA_W-1:0]       shift_out_q, shift_out_d, shift_in_q, shift_in_d;
    logic [DATA_W-1:0]       rx_data_q, rx_data_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]           chan_ptr_q, chan_ptr_d, rx_chan_q, rx_chan_d, chan_next;
    logic                    first_q, first_d, reload_q, reload_d;
    logic                    rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
    logic                    sclk_s, cs_s, mosi_s, sclk_edge, lead, trail;
    logic                    sample_edge, shift_edge, cs_fall, cs_rise, word_done, load_hit;
    logic [DATA_W-1:0]       entry_word, rx_word;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_edge   = sclk_s ^ sclk_prev_q;
    assign lead        = sclk_edge & (sclk_prev_q == CPOL);
    assign trail       = sclk_edge & (sclk_prev_q != CPOL);
    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;
    assign word_done   = (state_q == ACTIVE) && sample_edge && (bit_cnt_q == BW'(DATA_W - 1));
    assign chan_next   = (chan_ptr_q == CW'(CHANNELS - 1)) ? '0 : chan_ptr_q + 1'b1;
    assign load_hit    = load_we && (32'(load_chan) < CHANNELS);
    // A write landing on the entry cycle must be what the master sees first
    assign entry_word  = (load_hit && load_chan == chan_ptr_q) ? load_data : sample_q[chan_ptr_q];
    assign rx_word     = {shift_in_q[DATA_W-2:0], mosi_s};

    assign miso      = (state_q == ACTIVE) & shift_out_q[DATA_W-1];
    assign miso_oe   = (state_q == ACTIVE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_chan   = rx_chan_q;
    assign frame_err = frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sample_q <= '{default: '0};
        else if (load_hit) sample_q[load_chan] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_out_q <= '0;
            shift_in_q  <= '0;
            bit_cnt_q   <= '0;
            chan_ptr_q  <= '0;
            first_q     <= 1'b0;
            reload_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_chan_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_out_q <= shift_out_d;
            shift_in_q  <= shift_in_d;
            bit_cnt_q   <= bit_cnt_d;
            chan_ptr_q  <= chan_ptr_d;
            first_q     <= first_d;
            reload_q    <= reload_d;
            rx_data_q   <= rx_data_d;
            rx_chan_q   <= rx_chan_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_out_d = shift_out_q;
        shift_in_d  = shift_in_q;
        bit_cnt_d   = bit_cnt_q;
        chan_ptr_d  = chan_ptr_q;
        first_d     = first_q;
        reload_d    = reload_q;
        rx_data_d   = rx_data_q;
        rx_chan_d   = rx_chan_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d     = ACTIVE;
                shift_out_d = entry_word;
                bit_cnt_d   = '0;
                first_d     = CPHA;
                reload_d    = 1'b0;
            end
        end else begin
            // Shift edge after a completed word reloads the next channel for gapless bursts
            if (shift_edge) begin
                shift_out_d = first_q ? shift_out_q
                            : reload_q ? sample_q[chan_ptr_q]
                            : {shift_out_q[DATA_W-2:0], 1'b0};
                first_d     = 1'b0;
                reload_d    = 1'b0;
            end
            if (sample_edge) begin
                shift_in_d = rx_word;
                bit_cnt_d  = bit_cnt_q + 1'b1;
            end
            if (word_done) begin
                rx_data_d  = rx_word;
                rx_chan_d  = chan_ptr_q;
                rx_valid_d = 1'b1;
                chan_ptr_d = chan_next;
                bit_cnt_d  = '0;
                reload_d   = 1'b1;
            end
            if (cs_rise) begin
                state_d     = IDLE;
                frame_err_d = (bit_cnt_q != '0) && !word_done;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_adc.sv
// tb_spi_slave_adc: scoreboard bench driving one DUT per SPI mode from a shared sample-load bus.
module tb_spi_slave_adc;
    localparam int W    = 16;
    localparam int HALF = 8;

    typedef struct {
        int         m;
        logic [W-1:0] d;
        logic [1:0] c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   sclk_m = 4'b1100;
    logic [3:0]   mosi_m = 4'b0000;
    logic [3:0]   cs_m = 4'b1111;
    logic [3:0]   miso_m, oe_m, rxv_m, ferr_m;
    logic [W-1:0] rxd_m [4];
    logic [1:0]   rxc_m [4];
    logic         load_we = 1'b0;
    logic [1:0]   load_chan = 2'd0;
    logic [W-1:0] load_data = '0;
    int           errors = 0;
    int           checks = 0;
    int           ferr_cnt = 0;
    exp_t         exp_q[$];
    exp_t         e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_adc #(
            .DATA_W(W), .CHANNELS(4), .CPOL(g >= 2), .CPHA(g % 2 == 1), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .sclk(sclk_m[g]), .mosi(mosi_m[g]), .cs_n(cs_m[g]),
            .miso(miso_m[g]), .miso_oe(oe_m[g]), .load_we(load_we), .load_chan(load_chan),
            .load_data(load_data), .rx_data(rxd_m[g]), .rx_valid(rxv_m[g]),
            .rx_chan(rxc_m[g]), .frame_err(ferr_m[g])
        );
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (ferr_m[m]) ferr_cnt++;
            if (rxv_m[m]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: mode %0d data %0h chan %0d, none expected", m, rxd_m[m], rxc_m[m]);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_mode", m, e.m);
                    chk("rx_data", rxd_m[m], e.d);
                    chk("rx_chan", rxc_m[m], e.c);
                end
            end
        end
    end

    task automatic half();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] ch, input logic [W-1:0] d);
        @(posedge clk);
        #1 load_we = 1'b1; load_chan = ch; load_data = d;
        @(posedge clk);
        #1 load_we = 1'b0;
    endtask

    task automatic cs_low(input int m, input bit collide, input logic [1:0] ch, input logic [W-1:0] d);
        @(posedge clk);
        #1 cs_m[m] = 1'b0;
        if (collide) begin
            repeat (2) @(posedge clk);
            #1 load_we = 1'b1; load_chan = ch; load_data = d;
            @(posedge clk);
            #1 load_we = 1'b0;
        end
        half();
    endtask

    task automatic cs_high(input int m);
        half();
        cs_m[m] = 1'b1;
        half();
        half();
    endtask

    task automatic bitx(input int m, input logic b, output logic o);
        logic cpol = (m >= 2);
        logic cpha = (m % 2 == 1);
        if (!cpha) begin
            mosi_m[m] = b;
            half();
            o = miso_m[m];
            sclk_m[m] = ~cpol;
            half();
            sclk_m[m] = cpol;
        end else begin
            sclk_m[m] = ~cpol;
            mosi_m[m] = b;
            half();
            o = miso_m[m];
            sclk_m[m] = cpol;
            half();
        end
    endtask

    task automatic word(input int m, input logic [W-1:0] tx, input logic [W-1:0] xm,
                        input logic [1:0] xc, input string n);
        logic [W-1:0] r;
        exp_q.push_back('{m, tx, xc});
        for (int i = W - 1; i >= 0; i--) bitx(m, tx[i], r[i]);
        chk(n, r, xm);
    endtask

    task automatic frame(input int m, input logic [W-1:0] tx, input logic [W-1:0] xm,
                         input logic [1:0] xc, input string n);
        cs_low(m, 1'b0, 2'd0, '0);
        word(m, tx, xm, xc, n);
        cs_high(m);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic o;
        logic [W-1:0] t1 [4] = '{16'hA5A5, 16'h1234, 16'hFFFF, 16'h0001};
        logic [W-1:0] bt [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", oe_m, 0);
        chk("rst_miso", miso_m, 0);
        chk("rst_rxv", rxv_m, 0);
        chk("rst_ferr", ferr_m, 0);
        chk("rst_rxd", rxd_m[0], 0);
        chk("rst_rxc", rxc_m[0], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) load(2'(c), t1[c]);

        cs_low(0, 1'b0, 2'd0, '0);
        chk("oe_active", oe_m[0], 1);
        word(0, 16'hC3C3, t1[0], 2'd0, "t1_ch0");
        cs_high(0);
        chk("oe_idle", oe_m[0], 0);
        for (int c = 1; c < 4; c++) frame(0, 16'hC3C3, t1[c], 2'(c), $sformatf("t1_ch%0d", c));

        cs_low(0, 1'b0, 2'd0, '0);
        for (int k = 0; k < 5; k++) word(0, bt[k], t1[k % 4], 2'(k % 4), $sformatf("burst_w%0d", k));
        cs_high(0);

        cs_low(0, 1'b0, 2'd0, '0);
        for (int k = 0; k < 7; k++) bitx(0, 1'b1, o);
        cs_high(0);
        chk("abort_ferr", ferr_cnt, 1);
        chk("abort_no_rx", exp_q.size(), 0);
        frame(0, 16'h0F0F, t1[1], 2'd1, "abort_retry");

        cs_low(0, 1'b1, 2'd2, 16'hBEEF);
        word(0, 16'h6666, 16'hBEEF, 2'd2, "collide");
        cs_high(0);

        for (int m = 1; m < 4; m++) frame(m, 16'h5A5A, 16'hA5A5, 2'd0, $sformatf("mode%0d", m));

        cs_low(0, 1'b0, 2'd0, '0);
        for (int k = 0; k < 9; k++) bitx(0, 1'b0, o);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_oe", oe_m, 0);
        chk("arst_miso", miso_m[0], 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cs_high(0);
        frame(0, 16'h7777, 16'h0000, 2'd0, "arst_ch0");
        frame(0, 16'h8888, 16'h0000, 2'd1, "arst_ch1");

        chk("ferr_total", ferr_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
